// File: rtl/cmp_flag_pkg.sv
// Shared definitions for the condition-flag stage.
// Condition codes, FSM encoding and the {g,l,e} flag bundle.
package cmp_flag_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_HI = 4'b0010;
  localparam logic [3:0] COND_HS = 4'b0011;
  localparam logic [3:0] COND_LO = 4'b0100;
  localparam logic [3:0] COND_LS = 4'b0101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  typedef struct packed {
    logic g;
    logic l;
    logic e;
  } flags_t;

  function automatic logic is_one_hot(flags_t f);
    return (f.g ^ f.l ^ f.e) && !(f.g && f.l && f.e);
  endfunction

endpackage

// File: rtl/cmp_flag_stage_cond_eval.sv
// Combinational condition-code evaluator.
// Reserved codes yield take = 0 with illegal raised.
module cond_eval
  import cmp_flag_pkg::*;
(
  input  logic [2:0] flags,
  input  logic [3:0] cond_code,
  output logic       take,
  output logic       illegal
);

  flags_t f;
  assign f = flags_t'(flags);

  always_comb begin
    take    = 1'b0;
    illegal = 1'b0;
    unique case (1'b1)
      (cond_code == COND_EQ): take = f.e;
      (cond_code == COND_NE): take = !f.e;
      (cond_code == COND_HI): take = f.g;
      (cond_code == COND_HS): take = f.g | f.e;
      (cond_code == COND_LO): take = f.l;
      (cond_code == COND_LS): take = f.l | f.e;
      (cond_code == COND_AL): take = 1'b1;
      (cond_code == COND_NV): take = 1'b0;
      default:                illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cmp_flag_stage.sv
// Condition-flag stage: holds comparator flags, evaluates
// condition requests and returns a registered take decision.
module cmp_flag_stage
  import cmp_flag_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmp_valid,
  input  logic       greater,
  input  logic       less,
  input  logic       equal,
  input  logic       flush,
  input  logic       cond_valid,
  input  logic [3:0] cond_code,
  output logic       cond_ready,
  output logic       take_valid,
  output logic       take,
  output logic       illegal_cond,
  output logic       flag_err,
  output logic       flags_valid
);

  flags_t cmp_f;
  flags_t held_f;
  flags_t eval_f;
  logic   state_q;
  logic   legal;
  logic   fwd;
  logic   accept;
  logic   take_c;
  logic   ill_c;

  assign cmp_f  = flags_t'({greater, less, equal});
  assign legal  = cmp_valid && is_one_hot(cmp_f);
  assign fwd    = FWD_EN && legal;

  assign cond_ready =
    !flush && ((state_q == ST_FULL) || fwd);
  assign accept = cond_valid && cond_ready;

  // A same-cycle compare wins over the held copy
  assign eval_f = fwd ? cmp_f : held_f;

  assign flags_valid = (state_q == ST_FULL);

  cond_eval u_cond_eval (
    .flags     (eval_f),
    .cond_code (cond_code),
    .take      (take_c),
    .illegal   (ill_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      held_f  <= '0;
    end else if (flush) begin
      state_q <= ST_EMPTY;
    end else if (legal) begin
      state_q <= ST_FULL;
      held_f  <= cmp_f;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_err <= 1'b0;
    end else if (cmp_valid && !is_one_hot(cmp_f)) begin
      flag_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      take_valid   <= 1'b0;
      take         <= 1'b0;
      illegal_cond <= 1'b0;
    end else begin
      take_valid   <= accept;
      take         <= accept && take_c;
      illegal_cond <= accept && ill_c;
    end
  end

endmodule

// File: tb/tb_cmp_flag_stage.sv
// Directed plus random bench for cmp_flag_stage.
// Runs a forwarding and a non-forwarding instance side by side.
module tb_cmp_flag_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmp_valid, greater, less, equal;
  logic       flush, cond_valid;
  logic [3:0] cond_code;

  logic [1:0] rdy, tv, tk, il, fe, fv;

  always #5 clk = ~clk;

  cmp_flag_stage #(.FWD_EN(1'b1)) u_fwd (
    .clk          (clk),
    .reset        (reset),
    .cmp_valid    (cmp_valid),
    .greater      (greater),
    .less         (less),
    .equal        (equal),
    .flush        (flush),
    .cond_valid   (cond_valid),
    .cond_code    (cond_code),
    .cond_ready   (rdy[1]),
    .take_valid   (tv[1]),
    .take         (tk[1]),
    .illegal_cond (il[1]),
    .flag_err     (fe[1]),
    .flags_valid  (fv[1])
  );

  cmp_flag_stage #(.FWD_EN(1'b0)) u_nofwd (
    .clk          (clk),
    .reset        (reset),
    .cmp_valid    (cmp_valid),
    .greater      (greater),
    .less         (less),
    .equal        (equal),
    .flush        (flush),
    .cond_valid   (cond_valid),
    .cond_code    (cond_code),
    .cond_ready   (rdy[0]),
    .take_valid   (tv[0]),
    .take         (tk[0]),
    .illegal_cond (il[0]),
    .flag_err     (fe[0]),
    .flags_valid  (fv[0])
  );

  int checks = 0;
  int passes = 0;

  // Reference state, index = FWD_EN of the instance
  bit       mv[2];
  logic [2:0] mf[2];
  bit       merr[2];
  bit       etv[2], etk[2], eil[2];

  task automatic chk(string tag, int idx, logic obs, logic exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s fwd%0d observed=%0b expected=%0b",
                tag, idx, obs, exp);
  endtask

  function automatic bit ref_cond(logic [3:0] code,
                                  logic [2:0] f,
                                  output bit ill);
    bit g = f[2];
    bit l = f[1];
    bit e = f[0];
    ill = 1'b0;
    case (int'(code))
      0:  return e;
      1:  return !e;
      2:  return g;
      3:  return g || e;
      4:  return l;
      5:  return l || e;
      14: return 1'b1;
      15: return 1'b0;
      default: begin
        ill = 1'b1;
        return 1'b0;
      end
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mv[i] = 0; mf[i] = '0; merr[i] = 0;
      etv[i] = 0; etk[i] = 0; eil[i] = 0;
    end
  endtask

  task automatic check_outs();
    for (int i = 0; i < 2; i++) begin
      chk("take_valid", i, tv[i], etv[i]);
      chk("take", i, tk[i], etk[i]);
      chk("illegal_cond", i, il[i], eil[i]);
      chk("flags_valid", i, fv[i], mv[i]);
      chk("flag_err", i, fe[i], merr[i]);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge
  task automatic step(bit cv, bit g, bit l, bit e,
                      bit fl, bit qv, logic [3:0] code);
    bit oh, r, ill, t, usefwd;
    cmp_valid = cv; greater = g; less = l; equal = e;
    flush = fl; cond_valid = qv; cond_code = code;
    #1;
    oh = cv && ((int'(g) + int'(l) + int'(e)) == 1);
    for (int i = 0; i < 2; i++) begin
      usefwd = (i == 1) && oh;
      r = !fl && (mv[i] || usefwd);
      chk("cond_ready", i, rdy[i], r);
      t = ref_cond(code, usefwd ? {g, l, e} : mf[i], ill);
      etv[i] = qv && r;
      etk[i] = etv[i] && t;
      eil[i] = etv[i] && ill;
      if (cv && !oh) merr[i] = 1;
      if (fl) mv[i] = 0;
      else if (oh) begin
        mv[i] = 1;
        mf[i] = {g, l, e};
      end
    end
    @(posedge clk);
    #1;
    check_outs();
    @(negedge clk);
  endtask

  // Launch an AL request, then reset while its result is on the outputs
  task automatic mid_reset();
    step(0, 0, 0, 0, 0, 1, 4'b1110);
    cond_valid = 0;
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      chk("rst_take_valid", i, tv[i], 1'b0);
      chk("rst_take", i, tk[i], 1'b0);
      chk("rst_flags_valid", i, fv[i], 1'b0);
      chk("rst_cond_ready", i, rdy[i], 1'b0);
    end
    #1;
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    cmp_valid = 0; greater = 0; less = 0; equal = 0;
    flush = 0; cond_valid = 0; cond_code = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_ready", i, rdy[i], 1'b0);
    end
    check_outs();
    reset = 1'b0;
    @(negedge clk);

    // Stall with no flags
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0, 1, 4'b0000);

    // 5 vs 3: greater
    step(1, 1, 0, 0, 0, 0, 4'b0000);
    step(0, 0, 0, 0, 0, 1, 4'b0010);
    step(0, 0, 0, 0, 0, 1, 4'b0101);

    // Forwarding from EMPTY
    step(0, 0, 0, 0, 1, 0, 4'b0000);
    step(1, 0, 0, 1, 0, 1, 4'b0000);
    step(0, 0, 0, 0, 0, 1, 4'b0000);

    // Flush with compare and request in FULL
    step(1, 0, 1, 0, 1, 1, 4'b0100);
    step(0, 0, 0, 0, 0, 1, 4'b0100);
    step(1, 0, 1, 0, 0, 1, 4'b0100);
    step(0, 0, 0, 0, 0, 1, 4'b0100);

    // Illegal compare and reserved code
    step(1, 1, 1, 0, 0, 0, 4'b0000);
    step(0, 0, 0, 0, 0, 1, 4'b1010);
    step(1, 0, 0, 0, 0, 1, 4'b0100);

    // Back-to-back on equal flags, then async reset
    step(1, 0, 0, 1, 0, 0, 4'b0000);
    step(0, 0, 0, 0, 0, 1, 4'b1110);
    step(0, 0, 0, 0, 0, 1, 4'b1111);
    step(0, 0, 0, 0, 0, 1, 4'b0001);
    mid_reset();

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      bit cv, g, l, e, fl, qv;
      logic [3:0] code;
      int sel;
      cv = ($urandom % 2) == 0;
      sel = int'($urandom % 8);
      g = 0; l = 0; e = 0;
      if (sel < 6) begin
        g = (sel % 3) == 0; l = (sel % 3) == 1; e = (sel % 3) == 2;
      end else begin
        g = $urandom % 2; l = $urandom % 2; e = $urandom % 2;
      end
      fl = ($urandom % 8) == 0;
      qv = ($urandom % 4) != 0;
      code = 4'($urandom);
      step(cv, g, l, e, fl, qv, code);
      if (k == 200) mid_reset();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
